// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the shift sequencer.
//   state_t   : controller FSM states (IDLE, SHIFT, DONE)
//   DIR_LEFT  : dir value that shifts towards the MSB
//   DIR_RIGHT : dir value that shifts towards the LSB
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Command/status bundle for shift_seq_ctrl.
//   master : command source (start, dir, pdata, count, serial_in out; status in)
//   slave  : the sequencer (command in; dout, sout, busy, done out)
interface shift_seq_ctrl_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 3
);

  logic             start;
  logic             dir;
  logic [WIDTH-1:0] pdata;
  logic [CNT_W-1:0] count;
  logic             serial_in;
  logic [WIDTH-1:0] dout;
  logic             sout;
  logic             busy;
  logic             done;

  modport master (
    output start, dir, pdata, count, serial_in,
    input  dout, sout, busy, done
  );

  modport slave (
    input  start, dir, pdata, count, serial_in,
    output dout, sout, busy, done
  );

endinterface

// File: rtl/shift_seq_core.sv
// Shift register datapath.
//   clk, reset : clock, synchronous active-high reset (clears q)
//   load       : capture pdata (has priority over shift_en)
//   shift_en   : shift one place in direction dir, inserting in_bit
//   q          : register contents
module shift_seq_core
  import shift_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] pdata,
  input  logic             shift_en,
  input  logic             dir,
  input  logic             in_bit,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= '0;
    end else if (load) begin
      q_q <= pdata;
    end else if (shift_en) begin
      if (dir == DIR_LEFT) begin
        q_q <= {q_q[WIDTH-2:0], in_bit};
      end else begin
        q_q <= {in_bit, q_q[WIDTH-1:1]};
      end
    end
  end

  assign q = q_q;

endmodule

// File: rtl/shift_seq_ctrl.sv
// Shift sequencer: on start in IDLE, loads pdata and shifts it count times
// in direction dir, then pulses done for one cycle.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : shift_seq_ctrl_if slave (start/dir/pdata/count/serial_in in,
//           dout/sout/busy/done out)
// Build option: SHIFT_SEQ_ROTATE_EN feeds the leaving bit back in (rotate);
// serial_in is then ignored.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input logic             clk,
  input logic             reset,
  shift_seq_ctrl_if.slave bus
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             load;
  logic             shift_en;
  logic             in_bit;
  logic             sout;
  logic [WIDTH-1:0] q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dir_q   <= DIR_RIGHT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    load     = 1'b0;
    shift_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          dir_d   = bus.dir;
          cnt_d   = bus.count;
          state_d = (bus.count != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Bit leaving the register on this shift; forced low outside SHIFT.
  assign sout = shift_en ? ((dir_q == DIR_LEFT) ? q[WIDTH-1] : q[0]) : 1'b0;

`ifdef SHIFT_SEQ_ROTATE_EN
  assign in_bit = sout;
`else
  assign in_bit = bus.serial_in;
`endif

  shift_seq_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .pdata    (bus.pdata),
    .shift_en (shift_en),
    .dir      (dir_q),
    .in_bit   (in_bit),
    .q        (q)
  );

  assign bus.dout = q;
  assign bus.sout = sout;
  assign bus.busy = (state_q != IDLE);
  assign bus.done = (state_q == DONE);

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed self-checking bench for shift_seq_ctrl (WIDTH=4, CNT_W=3).
// Expected values follow SHIFT_SEQ_ROTATE_EN when it is defined.
module tb_shift_seq_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  shift_seq_ctrl_if #(.WIDTH(4), .CNT_W(3)) bus ();

  shift_seq_ctrl #(
    .WIDTH (4),
    .CNT_W (3)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one command from IDLE and follow it to completion. Inputs are
  // disturbed after acceptance; with repulse a second start is driven in SHIFT.
  task automatic run_cmd(input string tag, input logic [3:0] pd, input logic d,
                         input logic [2:0] cnt, input logic si, input bit repulse,
                         input logic [3:0] exp_dout, input logic [7:0] exp_sout,
                         input int exp_lat);
    int         lat;
    int         busy_cyc;
    int         extra_done;
    bit         seen;
    logic       sout_done;
    logic [3:0] dout_done;
    logic [7:0] souts;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.pdata     = pd;
    bus.dir       = d;
    bus.count     = cnt;
    bus.serial_in = si;
    lat = 0; busy_cyc = 0; seen = 1'b0; souts = '0; sout_done = 1'b0; dout_done = '0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      if (bus.busy) busy_cyc++;
      if (bus.done) begin
        seen      = 1'b1;
        sout_done = bus.sout;
        dout_done = bus.dout;
      end else begin
        souts = {souts[6:0], bus.sout};
      end
      bus.start = 1'b0;
      if (lat == 1) begin
        bus.pdata = ~pd;
        bus.dir   = ~d;
        bus.count = ~cnt;
        if (repulse) begin
          bus.start = 1'b1;
          bus.pdata = 4'b1111;
        end
      end
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_busy_cycles"}, 32'(busy_cyc), 32'(exp_lat));
    chk({tag, "_dout"}, 32'(dout_done), 32'(exp_dout));
    chk({tag, "_sout_seq"}, 32'(souts), 32'(exp_sout));
    chk({tag, "_sout_in_done"}, 32'(sout_done), 32'd0);
    extra_done = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.done) extra_done++;
    end
    chk({tag, "_single_done"}, 32'(extra_done), 32'd0);
    chk({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_dout_held"}, 32'(bus.dout), 32'(exp_dout));
  endtask

  initial begin : main
    int dones;
    bus.start     = 1'b1;  // reset must win over start
    bus.dir       = 1'b1;
    bus.pdata     = 4'b1111;
    bus.count     = 3'd2;
    bus.serial_in = 1'b0;
    reset         = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_dout", 32'(bus.dout), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_sout", 32'(bus.sout), 32'd0);
    bus.start = 1'b0;
    reset     = 1'b0;
    @(negedge clk);
    chk("idle_hold_dout", 32'(bus.dout), 32'd0);
    chk("idle_hold_busy", 32'(bus.busy), 32'd0);

`ifdef SHIFT_SEQ_ROTATE_EN
    run_cmd("left2",  4'b1011, 1'b1, 3'd2, 1'b0, 1'b0, 4'b1110, 8'h02, 3);
    run_cmd("right1", 4'b1011, 1'b0, 3'd1, 1'b1, 1'b0, 4'b1101, 8'h01, 2);
    run_cmd("zero",   4'b0110, 1'b1, 3'd0, 1'b0, 1'b0, 4'b0110, 8'h00, 1);
    run_cmd("busyrej",4'b1011, 1'b1, 3'd3, 1'b0, 1'b1, 4'b1101, 8'h05, 4);
    run_cmd("rot4",   4'b1001, 1'b1, 3'd4, 1'b0, 1'b0, 4'b1001, 8'h09, 5);
    run_cmd("long6",  4'b1011, 1'b1, 3'd6, 1'b1, 1'b0, 4'b1110, 8'h2e, 7);
`else
    run_cmd("left2",  4'b1011, 1'b1, 3'd2, 1'b0, 1'b0, 4'b1100, 8'h02, 3);
    run_cmd("right1", 4'b1011, 1'b0, 3'd1, 1'b1, 1'b0, 4'b1101, 8'h01, 2);
    run_cmd("zero",   4'b0110, 1'b1, 3'd0, 1'b0, 1'b0, 4'b0110, 8'h00, 1);
    run_cmd("busyrej",4'b1011, 1'b1, 3'd3, 1'b0, 1'b1, 4'b1000, 8'h05, 4);
    run_cmd("rot4",   4'b1001, 1'b1, 3'd4, 1'b0, 1'b0, 4'b0000, 8'h09, 5);
    run_cmd("long6",  4'b1011, 1'b1, 3'd6, 1'b1, 1'b0, 4'b1111, 8'h2f, 7);
`endif

    // Reset during the second SHIFT cycle of a count=3 command.
    @(negedge clk);
    bus.start     = 1'b1;
    bus.pdata     = 4'b1011;
    bus.dir       = 1'b1;
    bus.count     = 3'd3;
    bus.serial_in = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    chk("abort_busy_shift1", 32'(bus.busy), 32'd1);
    @(negedge clk);
    chk("abort_busy_shift2", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_dout", 32'(bus.dout), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_sout", 32'(bus.sout), 32'd0);
    reset = 1'b0;
    dones = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    chk("abort_no_done", 32'(dones), 32'd0);
    chk("abort_idle", 32'(bus.busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
